playbus_master: RTL and testbench
=================================

Name: playbus_master

Overview:
- Bus-master sequencer for the simplified PlayBus emulator.
- Generates the address and all slave strobes on the shared 4-bit data bus: EPROM, SRAM, switch buffer and display register.
- Slaves only respond; this block is the initiator. It runs single reads, single writes from the switches, and a block copy of EPROM to SRAM.
- Read data is returned to the user side and loaded into the display register.

Parameters:
- AW, 3, address width; the block copy covers 2**AW locations.
- DW, 4, data bus width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- n_reset  input  1  synchronous, active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- cmd  input  2  operation select:
  - 00: read EPROM
  - 01: read SRAM
  - 10: write SRAM from switches
  - 11: copy whole EPROM to SRAM
- addr_in  input  AW  target address; ignored for cmd 11.
- data  input  DW  shared data bus, observed only; the master never drives it.
- contend  input  1  bus contention flag from the contention monitor.
- Z  input  1  bus-floating flag from the contention monitor.
- address  output  AW  bus address.
- rom_cs, rom_oe  output  1 each  EPROM select and output enable.
- ram_cs, ram_oe, ram_we  output  1 each  SRAM select, output enable and write enable.
- sw_en  output  1  switch buffer enable; drives both its OE and CS.
- reg_oe  output  1  display register load enable.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  one-cycle completion pulse.
- rdata  output  DW  last read value.
- error  output  1  sticky bus-fault flag.

Behaviour:
- Reset (n_reset=0 at a clock edge):
  - FSM goes to IDLE.
  - address=0; all strobes, busy, done and error = 0; rdata=0.
  - Reset mid-transaction aborts immediately. Strobes are low the cycle after the edge. No SRAM write occurs on the reset edge.
- States: IDLE, SETUP, XFER, DONE.
- IDLE:
  - All strobes low.
  - start=1 latches cmd and addr_in (cmd 11 loads address 0) and moves to SETUP.
- SETUP (1 cycle):
  - address valid.
  - Source slave enabled: rom_cs+rom_oe for cmd 00/11, ram_cs+ram_oe for cmd 01, sw_en for cmd 10.
  - Write target ram_cs held for cmd 10/11, with ram_oe=0.
  - ram_we=0. This cycle is the settle cycle.
- XFER (1 cycle):
  - Same enables as SETUP.
  - Reads (00/01): reg_oe=1; rdata<=data on the exiting edge.
  - Writes (10/11): ram_we=1 for exactly this cycle, so the SRAM captures on the exiting edge.
  - Read and write never coexist, and ram_oe and ram_we are never both 1.
- Next state after XFER:
  - cmd 11 with address < 2**AW-1: address+1, then SETUP.
  - Otherwise: DONE.
- DONE (1 cycle):
  - done=1, all strobes low, address held.
  - Then IDLE. start is not sampled in DONE.
- Latency:
  - Single operation: start accepted at edge E0 → done high in the cycle after edge E2; the block is ready again at E3.
  - Copy: done at 2*2**AW+1 cycles after acceptance (17 for AW=3).
- Boundaries:
  - The copy address stops at 2**AW-1; there is no wrap past it.
  - start while busy is ignored; no queuing.
- error:
  - Cleared only by reset or by acceptance of a new start.

Optional Feature:
- Macro: PB_CONTEND_CHECK_EN.
- Defined:
  - In XFER, contend=1 sets error and aborts to DONE. ram_we is forced to 0 in that cycle, and rdata is not updated.
  - A read XFER with Z=1 sets error but completes normally.
- Undefined:
  - contend and Z are ignored; error is tied to 0.

Test Plan:
- Reset, then cmd=00, addr_in=5, start:
  - rom_cs/rom_oe high for 2 cycles.
  - rdata=0111; reg_oe pulses once.
  - done pulses 3 cycles after acceptance.
- cmd=11, start:
  - address steps 0..7; exactly 8 ram_we pulses, each in XFER; done at cycle 17.
  - Then cmd=01, addr_in=6 → rdata=0101.
- Switches=1010, cmd=10, addr_in=2:
  - sw_en and ram_cs high, ram_we high for 1 cycle.
  - A subsequent RAM read of address 2 returns 1010.
- start pulsed during a copy at address 3:
  - Ignored; the copy completes unchanged.
- n_reset=0 during XFER of cmd=10:
  - Next cycle all strobes, busy and done are 0.
  - The RAM location is unchanged; rdata=0.
- With PB_CONTEND_CHECK_EN, force contend=1 during XFER of cmd=10:
  - error=1, no ram_we pulse, done pulses next cycle.
  - The next start clears error.

Source files
------------

// File: rtl/playbus_master_if.sv
// PlayBus shared-bus signal bundle: address, slave strobes, 4-bit data bus and
// the contention monitor's flags.
interface playbus_master_if #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 4
);
    logic [AW-1:0] address;
    logic          rom_cs;
    logic          rom_oe;
    logic          ram_cs;
    logic          ram_oe;
    logic          ram_we;
    logic          sw_en;
    logic          reg_oe;
    logic [DW-1:0] data;
    logic          contend;
    logic          Z;

    modport master (
        output address, rom_cs, rom_oe, ram_cs, ram_oe, ram_we, sw_en, reg_oe,
        input  data, contend, Z
    );

    modport slave (
        input  address, rom_cs, rom_oe, ram_cs, ram_oe, ram_we, sw_en, reg_oe,
        output data
    );

    modport monitor (
        input  address, rom_cs, rom_oe, ram_cs, ram_oe, ram_we, sw_en, reg_oe, data,
        output contend, Z
    );
endinterface

// File: rtl/playbus_master.sv
// PlayBus bus-master sequencer: single reads/writes and EPROM-to-SRAM block copy.
// Optional contention/float checking is enabled with PB_CONTEND_CHECK_EN.
module playbus_master #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 4
) (
    input  logic           clk,
    input  logic           n_reset,
    input  logic           start,
    input  logic [1:0]     cmd,
    input  logic [AW-1:0]  addr_in,
    output logic           busy,
    output logic           done,
    output logic [DW-1:0]  rdata,
    output logic           error,
    playbus_master_if.master bus
);

    typedef enum logic [1:0] {StIdle, StSetup, StXfer, StDone} state_e;

    localparam logic [AW-1:0] AddrMax = '1;

    state_e        state_q;
    logic [1:0]    cmd_q;
    logic [AW-1:0] address_q;
    logic          rom_en_q, ram_cs_q, ram_rd_q, sw_en_q, reg_oe_q, we_q;
    logic          busy_q, done_q;
    logic [DW-1:0] rdata_q;
    logic          is_read, is_write, is_copy;
    logic          xfer_fault;

    assign is_read  = ~cmd_q[1];
    assign is_write = cmd_q[1];
    assign is_copy  = (cmd_q == 2'b11);

`ifdef PB_CONTEND_CHECK_EN
    logic error_q;

    assign xfer_fault = bus.contend;
    assign error      = error_q;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            error_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            error_q <= 1'b0;
        end else if (state_q == StXfer && (bus.contend || (is_read && bus.Z))) begin
            error_q <= 1'b1;
        end
    end
`else
    logic unused_flags;

    assign unused_flags = bus.contend ^ bus.Z;
    assign xfer_fault   = 1'b0;
    assign error        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q   <= StIdle;
            cmd_q     <= 2'b00;
            address_q <= '0;
            rom_en_q  <= 1'b0;
            ram_cs_q  <= 1'b0;
            ram_rd_q  <= 1'b0;
            sw_en_q   <= 1'b0;
            reg_oe_q  <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cmd_q     <= cmd;
                        address_q <= (cmd == 2'b11) ? '0 : addr_in;
                        // Source enables plus the SRAM select for write targets
                        rom_en_q  <= (cmd == 2'b00) || (cmd == 2'b11);
                        ram_rd_q  <= (cmd == 2'b01);
                        sw_en_q   <= (cmd == 2'b10);
                        ram_cs_q  <= (cmd != 2'b00);
                        busy_q    <= 1'b1;
                        state_q   <= StSetup;
                    end
                end
                StSetup: begin
                    reg_oe_q <= is_read;
                    we_q     <= is_write;
                    state_q  <= StXfer;
                end
                StXfer: begin
                    reg_oe_q <= 1'b0;
                    we_q     <= 1'b0;
                    if (is_read && !xfer_fault) begin
                        rdata_q <= bus.data;
                    end
                    if (is_copy && address_q != AddrMax && !xfer_fault) begin
                        address_q <= address_q + 1'b1;
                        state_q   <= StSetup;
                    end else begin
                        rom_en_q <= 1'b0;
                        ram_cs_q <= 1'b0;
                        ram_rd_q <= 1'b0;
                        sw_en_q  <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.address = address_q;
    assign bus.rom_cs  = rom_en_q;
    assign bus.rom_oe  = rom_en_q;
    assign bus.ram_cs  = ram_cs_q;
    assign bus.ram_oe  = ram_rd_q;
    assign bus.sw_en   = sw_en_q;
    assign bus.reg_oe  = reg_oe_q;
    // Gating with reset keeps the SRAM from capturing on an aborting reset edge
    assign bus.ram_we  = we_q & n_reset & ~xfer_fault;
    assign busy        = busy_q;
    assign done        = done_q;
    assign rdata       = rdata_q;

endmodule

// File: tb/tb_playbus_master.sv
// Directed bench for playbus_master with behavioural EPROM, SRAM and switch models.
module tb_playbus_master;
    localparam int unsigned AW = 3;
    localparam int unsigned DW = 4;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          start;
    logic [1:0]    cmd;
    logic [AW-1:0] addr_in;
    logic          busy, done, error;
    logic [DW-1:0] rdata;

    logic [DW-1:0] rom [8];
    logic [DW-1:0] ram [8] = '{default: '0};
    logic [DW-1:0] switches;
    logic          contend_force;

    int checks = 0;
    int passed = 0;
    int we_cnt = 0, rom_cnt = 0, regoe_cnt = 0, overlap_cnt = 0;
    logic [AW-1:0] we_log [$];

    always #5 clk = ~clk;

    playbus_master_if #(.AW(AW), .DW(DW)) pb ();

    playbus_master #(.AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .start   (start),
        .cmd     (cmd),
        .addr_in (addr_in),
        .busy    (busy),
        .done    (done),
        .rdata   (rdata),
        .error   (error),
        .bus     (pb)
    );

    always_comb begin
        pb.data = '0;
        pb.Z    = 1'b0;
        if (pb.rom_cs && pb.rom_oe)      pb.data = rom[pb.address];
        else if (pb.ram_cs && pb.ram_oe) pb.data = ram[pb.address];
        else if (pb.sw_en)               pb.data = switches;
        else                             pb.Z    = 1'b1;
    end
    assign pb.contend = contend_force;

    always @(posedge clk) begin
        if (pb.ram_cs && pb.ram_we) ram[pb.address] <= pb.data;
    end

    always @(posedge clk) begin
        if (pb.ram_we) begin
            we_cnt++;
            we_log.push_back(pb.address);
        end
        if (pb.ram_we && pb.ram_oe) overlap_cnt++;
        if (pb.rom_cs && pb.rom_oe) rom_cnt++;
        if (pb.reg_oe) regoe_cnt++;
    end

    function automatic logic [6:0] strobes();
        return {pb.rom_cs, pb.rom_oe, pb.ram_cs, pb.ram_oe, pb.ram_we, pb.sw_en, pb.reg_oe};
    endfunction

    task automatic issue(input logic [1:0] c, input logic [AW-1:0] a);
        @(negedge clk);
        cmd = c; addr_in = a; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles after the accepting edge until done is seen high
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cycles++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 n_reset = 1'b1;
        @(negedge clk);
        checks++; if (strobes() !== 7'b0) $display("FAIL reset_strobes: got %b expected 0000000", strobes()); else passed++;
        checks++; if (pb.address !== 3'd0) $display("FAIL reset_addr: got %0d expected 0", pb.address); else passed++;
        checks++; if ({busy, done, error} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy, done, error}); else passed++;
        checks++; if (rdata !== 4'h0) $display("FAIL reset_rdata: got %h expected 0", rdata); else passed++;
    endtask

    task automatic test_read_rom();
        int cyc, r0, g0;
        r0 = rom_cnt; g0 = regoe_cnt;
        issue(2'b00, 3'd5);
        wait_done(cyc);
        checks++; if (cyc !== 3) $display("FAIL rom_latency: got %0d expected 3", cyc); else passed++;
        checks++; if (rdata !== 4'b0111) $display("FAIL rom_rdata: got %b expected 0111", rdata); else passed++;
        checks++; if (rom_cnt - r0 !== 2) $display("FAIL rom_oe_cycles: got %0d expected 2", rom_cnt - r0); else passed++;
        checks++; if (regoe_cnt - g0 !== 1) $display("FAIL rom_reg_oe: got %0d expected 1", regoe_cnt - g0); else passed++;
        checks++; if (pb.address !== 3'd5) $display("FAIL rom_addr_held: got %0d expected 5", pb.address); else passed++;
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) $display("FAIL rom_ready: got %b expected 00", {busy, done}); else passed++;
    endtask

    task automatic test_copy();
        int cyc, w0, base;
        logic ok;
        w0 = we_cnt; base = we_log.size();
        issue(2'b11, 3'd5);
        wait_done(cyc);
        checks++; if (cyc !== 17) $display("FAIL copy_latency: got %0d expected 17", cyc); else passed++;
        checks++; if (we_cnt - w0 !== 8) $display("FAIL copy_we_count: got %0d expected 8", we_cnt - w0); else passed++;
        checks++; if (pb.address !== 3'd7) $display("FAIL copy_end_addr: got %0d expected 7", pb.address); else passed++;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (base + i >= we_log.size() || we_log[base + i] !== i[2:0]) ok = 1'b0;
            if (ram[i] !== rom[i]) ok = 1'b0;
        end
        checks++; if (ok !== 1'b1) $display("FAIL copy_order_contents: got %b expected 1", ok); else passed++;
        checks++; if (overlap_cnt !== 0) $display("FAIL copy_oe_we_overlap: got %0d expected 0", overlap_cnt); else passed++;
        @(negedge clk);
        issue(2'b01, 3'd6);
        wait_done(cyc);
        checks++; if (rdata !== 4'b0101) $display("FAIL copy_readback: got %b expected 0101", rdata); else passed++;
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int cyc, w0;
        w0 = we_cnt;
        issue(2'b11, 3'd0);
        repeat (7) @(negedge clk);
        checks++; if (pb.address !== 3'd3) $display("FAIL busy_at_addr3: got %0d expected 3", pb.address); else passed++;
        cmd = 2'b00; addr_in = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        cyc += 8;
        checks++; if (cyc !== 17) $display("FAIL busy_latency: got %0d expected 17", cyc); else passed++;
        checks++; if (we_cnt - w0 !== 8) $display("FAIL busy_we_count: got %0d expected 8", we_cnt - w0); else passed++;
        repeat (3) @(negedge clk);
        checks++; if ({busy, rdata} !== 5'b0_0101) $display("FAIL busy_no_queue: got %b expected 00101", {busy, rdata}); else passed++;
    endtask

    task automatic test_write_sw();
        int cyc, w0;
        w0 = we_cnt;
        switches = 4'b1010;
        issue(2'b10, 3'd2);
        @(negedge clk);
        checks++; if (strobes() !== 7'b0010010) $display("FAIL wr_setup_strobes: got %b expected 0010010", strobes()); else passed++;
        @(negedge clk);
        checks++; if (strobes() !== 7'b0010110) $display("FAIL wr_xfer_strobes: got %b expected 0010110", strobes()); else passed++;
        @(negedge clk);
        checks++; if (done !== 1'b1) $display("FAIL wr_done: got %b expected 1", done); else passed++;
        checks++; if (we_cnt - w0 !== 1) $display("FAIL wr_we_count: got %0d expected 1", we_cnt - w0); else passed++;
        @(negedge clk);
        issue(2'b01, 3'd2);
        wait_done(cyc);
        checks++; if (rdata !== 4'b1010) $display("FAIL wr_readback: got %b expected 1010", rdata); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        switches = 4'b1111;
        issue(2'b10, 3'd4);
        @(negedge clk);
        @(negedge clk);
        checks++; if (pb.ram_we !== 1'b1) $display("FAIL abort_in_xfer: got %b expected 1", pb.ram_we); else passed++;
        n_reset = 1'b0;
        @(negedge clk);
        checks++; if ({strobes(), busy, done} !== 9'b0) $display("FAIL abort_outputs: got %b expected 000000000", {strobes(), busy, done}); else passed++;
        checks++; if (ram[4] !== 4'b0001) $display("FAIL abort_ram: got %b expected 0001", ram[4]); else passed++;
        checks++; if (rdata !== 4'h0) $display("FAIL abort_rdata: got %h expected 0", rdata); else passed++;
        n_reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_contend();
        int cyc, w0;
        w0 = we_cnt;
        switches = 4'b0110;
        issue(2'b10, 3'd3);
        @(negedge clk);
        @(negedge clk);
        contend_force = 1'b1;
        #1;
`ifdef PB_CONTEND_CHECK_EN
        checks++; if (pb.ram_we !== 1'b0) $display("FAIL cont_we_forced: got %b expected 0", pb.ram_we); else passed++;
        @(negedge clk);
        contend_force = 1'b0;
        checks++; if ({done, error} !== 2'b11) $display("FAIL cont_done_err: got %b expected 11", {done, error}); else passed++;
        @(negedge clk);
        checks++; if (ram[3] !== 4'hE) $display("FAIL cont_ram: got %h expected e", ram[3]); else passed++;
        checks++; if (we_cnt - w0 !== 0) $display("FAIL cont_we_count: got %0d expected 0", we_cnt - w0); else passed++;
        issue(2'b00, 3'd0);
        @(negedge clk);
        checks++; if (error !== 1'b0) $display("FAIL cont_err_clear: got %b expected 0", error); else passed++;
        wait_done(cyc);
        checks++; if (rdata !== 4'h3) $display("FAIL cont_next_read: got %h expected 3", rdata); else passed++;
`else
        checks++; if (pb.ram_we !== 1'b1) $display("FAIL nocont_we: got %b expected 1", pb.ram_we); else passed++;
        @(negedge clk);
        contend_force = 1'b0;
        checks++; if ({done, error} !== 2'b10) $display("FAIL nocont_done_err: got %b expected 10", {done, error}); else passed++;
        @(negedge clk);
        checks++; if (ram[3] !== 4'b0110) $display("FAIL nocont_ram: got %b expected 0110", ram[3]); else passed++;
        checks++; if (we_cnt - w0 !== 1) $display("FAIL nocont_we_count: got %0d expected 1", we_cnt - w0); else passed++;
`endif
        @(negedge clk);
    endtask

    initial begin
        rom[0] = 4'h3; rom[1] = 4'h9; rom[2] = 4'hC; rom[3] = 4'hE;
        rom[4] = 4'h1; rom[5] = 4'h7; rom[6] = 4'h5; rom[7] = 4'hA;
        start = 1'b0; cmd = 2'b00; addr_in = '0; switches = '0; contend_force = 1'b0;
        n_reset = 1'b0;
        test_reset();
        test_read_rom();
        test_copy();
        test_start_while_busy();
        test_write_sw();
        test_reset_abort();
        test_contend();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
